x_input_conditioner: RTL and testbench
======================================

X_INPUT_CONDITIONER -- requirements
Module: x_input_conditioner

Interface
REQ-001: Parameter STABLE_CYCLES, default 8: consecutive synchronized samples at the new level required before the output changes; legal range 2..2**CNT_W-1.
REQ-002: Parameter CNT_W, default 4: stability counter width.
REQ-003: c  input  1  single clock; all state changes on its rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately, release is synchronous to c.
REQ-005: raw_in  input  1  asynchronous, bouncing raw level (switch/external line).
REQ-006: x  output  1  registered clean level; drives the x input of the downstream state-diagram FSM.
REQ-007: x_rise  output  1  registered one-cycle pulse on the cycle x goes 0->1.
REQ-008: x_fall  output  1  registered one-cycle pulse on the cycle x goes 1->0.
REQ-009: busy  output  1  registered; 1 while a level change is being qualified (CHK_HIGH or CHK_LOW).

Function
REQ-010: raw_in SHALL pass through a two-flop synchronizer (sync1 -> s), both flops cleared by reset; no other logic reads raw_in.
REQ-011: Debounce FSM SHALL have exactly four states: LOW, CHK_HIGH, HIGH, CHK_LOW; encoding is implementer's choice.
REQ-012: LOW: s=1 -> CHK_HIGH, cnt=1; s=0 -> stay, cnt=0.
REQ-013: CHK_HIGH: s=0 -> LOW, cnt=0, no pulse; s=1 and cnt=STABLE_CYCLES-1 -> HIGH, cnt=0; otherwise cnt+1.
REQ-014: HIGH: s=0 -> CHK_LOW, cnt=1; s=1 -> stay, cnt=0.
REQ-015: CHK_LOW: s=1 -> HIGH, cnt=0, no pulse; s=0 and cnt=STABLE_CYCLES-1 -> LOW, cnt=0; otherwise cnt+1.
REQ-016: x SHALL be 1 exactly when the FSM is in HIGH or CHK_LOW.
REQ-017: x_rise SHALL be 1 for exactly the one cycle following the CHK_HIGH->HIGH edge; x_fall likewise for CHK_LOW->LOW; never both high.
REQ-018: busy SHALL be 1 exactly when the FSM is in CHK_HIGH or CHK_LOW.
REQ-019: Latency: raw_in changing before edge k and held SHALL change x after edge k+STABLE_CYCLES+1 (default: edge k+9).
REQ-020: A raw_in excursion sampled for fewer than STABLE_CYCLES consecutive synchronized cycles SHALL leave x unchanged and produce no pulse.
REQ-021: Any return of s to the current x level during qualification SHALL restart qualification from zero on the next opposite sample.
REQ-022: cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-023: reset=0 SHALL force, asynchronously: sync1=0, s=0, state=LOW, cnt=0, x=0, x_rise=0, x_fall=0, busy=0.
REQ-024: Reset asserted mid-qualification or while HIGH SHALL abort with no pulse; x_fall SHALL NOT be generated by reset.
REQ-025: raw_in=1 at reset release SHALL be qualified normally: x rises after edge STABLE_CYCLES+1 counted from the first edge after release, with x_rise.

Verification
REQ-026: Reset then raw_in 0->1 before edge 0, held -> x=1 and x_rise=1 after edge 9, x_rise=0 after edge 10, busy=1 after edges 2..8.
REQ-027: x=1 steady, raw_in 1->0 held -> x=0 and x_fall pulse after edge 9 (relative), single cycle.
REQ-028: Bounce: raw_in toggles 1,0,1,0,1 each 3 cycles, then held 1 -> no pulse during bounce; x=1 nine edges after the final rising change.
REQ-029: Glitch: raw_in high for 7 cycles then low (STABLE_CYCLES=8) -> x stays 0, no x_rise, busy returns to 0.
REQ-030: reset pulsed low between edges while in CHK_LOW -> all outputs 0 immediately, no x_fall; with raw_in held 1 afterwards -> x re-rises 9 edges after release.
REQ-031: Rerun REQ-026 with STABLE_CYCLES=2 -> x=1 after edge 3.

Source files
------------

// File: rtl/x_input_conditioner.sv
// x_input_conditioner: synchronizes and debounces a bouncing raw level and
// produces a clean registered level plus one-cycle edge pulses.
//
// Ports:
//   c       input   clock, all state changes on the rising edge
//   reset   input   asynchronous active-low reset
//   raw_in  input   asynchronous raw level (switch / external line)
//   x       output  registered clean level
//   x_rise  output  registered one-cycle pulse when x goes 0->1
//   x_fall  output  registered one-cycle pulse when x goes 1->0
//   busy    output  registered, high while a level change is being qualified
module x_input_conditioner #(
   parameter int unsigned STABLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 4
) (
   input  logic c,
   input  logic reset,
   input  logic raw_in,
   output logic x,
   output logic x_rise,
   output logic x_fall,
   output logic busy
);

   localparam logic [1:0] LOW      = 2'd0;
   localparam logic [1:0] CHK_HIGH = 2'd1;
   localparam logic [1:0] HIGH     = 2'd2;
   localparam logic [1:0] CHK_LOW  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1;
   logic             s;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             x_nxt;
   logic             x_rise_nxt;
   logic             x_fall_nxt;
   logic             busy_nxt;

   // Two-flop synchronizer; the only reader of raw_in.
   always_ff @(posedge c or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync1 <= raw_in;
         s     <= sync1;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge c or negedge reset) begin
      if (!reset) begin
         state  <= LOW;
         cnt    <= '0;
         x      <= 1'b0;
         x_rise <= 1'b0;
         x_fall <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         x      <= x_nxt;
         x_rise <= x_rise_nxt;
         x_fall <= x_fall_nxt;
         busy   <= busy_nxt;
      end
   end

   // Next-state / counter logic; outputs are decoded from the next state so
   // they change on the same edge as the state itself.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      x_rise_nxt = 1'b0;
      x_fall_nxt = 1'b0;

      case (state)
         LOW: begin
            if (s) begin
               state_nxt = CHK_HIGH;
               cnt_nxt   = CNT_W'(1);
            end else begin
               cnt_nxt   = '0;
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_nxt = LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = HIGH;
               cnt_nxt    = '0;
               x_rise_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s) begin
               state_nxt = CHK_LOW;
               cnt_nxt   = CNT_W'(1);
            end else begin
               cnt_nxt   = '0;
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt  = LOW;
               cnt_nxt    = '0;
               x_fall_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = LOW;
            cnt_nxt   = '0;
         end
      endcase

      x_nxt    = (state_nxt == HIGH)     || (state_nxt == CHK_LOW);
      busy_nxt = (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
   end

endmodule

// File: tb/tb_x_input_conditioner.sv
// tb_x_input_conditioner: directed bench for x_input_conditioner, default
// STABLE_CYCLES=8 instance plus a STABLE_CYCLES=2 instance on the same inputs.
module tb_x_input_conditioner;

   logic c = 1'b0;
   logic reset;
   logic raw_in;
   logic x, x_rise, x_fall, busy;
   logic x2, x_rise2, x_fall2, busy2;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 c = ~c;

   x_input_conditioner dut (
      .c      (c),
      .reset  (reset),
      .raw_in (raw_in),
      .x      (x),
      .x_rise (x_rise),
      .x_fall (x_fall),
      .busy   (busy)
   );

   x_input_conditioner #(.STABLE_CYCLES(2), .CNT_W(4)) dut2 (
      .c      (c),
      .reset  (reset),
      .raw_in (raw_in),
      .x      (x2),
      .x_rise (x_rise2),
      .x_fall (x_fall2),
      .busy   (busy2)
   );

   task automatic check_bit(input string tag, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge c);
      #1;
   endtask

   initial begin
      reset  = 1'b0;
      raw_in = 1'b0;
      step();
      step();

      // Reset state.
      check_bit("rst_x",      x,      1'b0);
      check_bit("rst_x_rise", x_rise, 1'b0);
      check_bit("rst_x_fall", x_fall, 1'b0);
      check_bit("rst_busy",   busy,   1'b0);

      // Release reset with raw_in already high; edge 0 is the next edge.
      reset  = 1'b1;
      raw_in = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         step();
         check_bit($sformatf("rise_x_e%0d", e),      x,      1'(e >= 9));
         check_bit($sformatf("rise_pulse_e%0d", e),  x_rise, 1'(e == 9));
         check_bit($sformatf("rise_nofall_e%0d", e), x_fall, 1'b0);
         check_bit($sformatf("rise_busy_e%0d", e),   busy,   1'(e >= 2 && e <= 8));
         check_bit($sformatf("s2_x_e%0d", e),        x2,     1'(e >= 3));
         check_bit($sformatf("s2_pulse_e%0d", e),    x_rise2, 1'(e == 3));
      end

      // Steady high, then fall.
      raw_in = 1'b0;
      for (int e = 0; e <= 10; e++) begin
         step();
         check_bit($sformatf("fall_x_e%0d", e),      x,      1'(e < 9));
         check_bit($sformatf("fall_pulse_e%0d", e),  x_fall, 1'(e == 9));
         check_bit($sformatf("fall_norise_e%0d", e), x_rise, 1'b0);
         check_bit($sformatf("fall_busy_e%0d", e),   busy,   1'(e >= 2 && e <= 8));
      end

      // Glitch: 7 cycles high is one short of qualifying.
      raw_in = 1'b1;
      for (int e = 0; e <= 15; e++) begin
         step();
         if (e == 6) raw_in = 1'b0;
         check_bit($sformatf("glitch_x_e%0d", e),    x,      1'b0);
         check_bit($sformatf("glitch_rise_e%0d", e), x_rise, 1'b0);
         check_bit($sformatf("glitch_busy_e%0d", e), busy,   1'(e >= 2 && e <= 8));
      end

      // Bounce 1,0,1,0 for 3 cycles each, then final rise held.
      for (int e = 0; e <= 11; e++) begin
         raw_in = 1'(((e / 3) % 2) == 0);
         step();
         check_bit($sformatf("bounce_x_e%0d", e),    x,      1'b0);
         check_bit($sformatf("bounce_rise_e%0d", e), x_rise, 1'b0);
         check_bit($sformatf("bounce_fall_e%0d", e), x_fall, 1'b0);
      end
      raw_in = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         step();
         check_bit($sformatf("bfinal_x_e%0d", e),    x,      1'(e >= 9));
         check_bit($sformatf("bfinal_rise_e%0d", e), x_rise, 1'(e == 9));
      end

      // Reset in the middle of CHK_LOW.
      raw_in = 1'b0;
      for (int e = 0; e <= 3; e++) step();
      check_bit("chklow_x",    x,    1'b1);
      check_bit("chklow_busy", busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      check_bit("midrst_x",      x,      1'b0);
      check_bit("midrst_x_rise", x_rise, 1'b0);
      check_bit("midrst_x_fall", x_fall, 1'b0);
      check_bit("midrst_busy",   busy,   1'b0);
      raw_in = 1'b1;
      #1 reset = 1'b1;
      for (int e = 0; e <= 10; e++) begin
         step();
         check_bit($sformatf("rerise_x_e%0d", e),    x,      1'(e >= 9));
         check_bit($sformatf("rerise_rise_e%0d", e), x_rise, 1'(e == 9));
         check_bit($sformatf("rerise_fall_e%0d", e), x_fall, 1'b0);
         check_bit($sformatf("rerise_busy_e%0d", e), busy,   1'(e >= 2 && e <= 8));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
